flash_mem_model: RTL and testbench

- Parametrised, cycle-accurate parallel-flash behavioural model for the CPU simulation bench.
- Replaces the zero-latency combinational flash lookup with:
  - configurable access latency;
  - 8- or 16-bit data bus;
  - configurable depth and byte order;
  - CE_N/OE_N bus handshake with tri-state data;
  - erased-flash behaviour on out-of-range addresses.
- Sits between the mips_cpu FL_* pins and the hex image loaded at time zero.

---
 rtl/flash_mem_model_if.sv | 15 +
 rtl/flash_mem_model.sv | 171 +++++++++++++++++
 tb/tb_flash_mem_model.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_mem_model_if.sv
// Parallel-flash control and address pins shared by the CPU bench and the flash model.
// The data bus stays a plain inout port on the model so tri-state resolution is local to it.
interface flash_mem_model_if #(
    parameter int ADDR_W = 22
);
    logic [ADDR_W-1:0] FL_ADDR;
    logic              FL_CE_N;
    logic              FL_OE_N;
    logic              FL_WE_N;
    logic              FL_RST_N;
    logic              FL_RY;

    modport master (output FL_ADDR, FL_CE_N, FL_OE_N, FL_WE_N, FL_RST_N, input FL_RY);
    modport slave  (input FL_ADDR, FL_CE_N, FL_OE_N, FL_WE_N, FL_RST_N, output FL_RY);
endinterface

// File: rtl/flash_mem_model.sv
// Cycle-accurate parallel-flash model: latency, 8/16-bit lanes, byte order, erased out-of-range.
// Optional FLASH_PROGRAM_EN adds WE_N-driven programming (bits clear only) with a busy period.
//
// state  | meaning
// IDLE   | no read selected, FL_DQ released
// ACCESS | address latched, latency counter running (FL_DQ released)
// VALID  | dout_q holds the addressed lane, driven while selected
module flash_mem_model #(
    parameter int    ADDR_W      = 22,
    parameter int    DQ_W        = 8,
    parameter int    DEPTH_WORDS = 32768,
    parameter int    LATENCY     = 3,
    parameter bit    BIG_ENDIAN  = 1'b1,
    parameter string INIT_FILE   = "",
    parameter int    PROG_CYCLES = 8
) (
    input  logic              clk,
    input  logic              Reset_n,
    flash_mem_model_if.slave  bus,
    inout  wire  [DQ_W-1:0]   FL_DQ,
    output logic [31:0]       rd_count
);
    localparam int       LANES    = 32 / DQ_W;
    localparam int       MEM_AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int       IDX_W    = ADDR_W - 2;
    localparam bit [3:0] CNT_LOAD = 4'(LATENCY - 1);

    if (!(DQ_W == 8 || DQ_W == 16) || LATENCY < 1 || LATENCY > 15 ||
        PROG_CYCLES < 1 || PROG_CYCLES > 65535) begin : g_bad_param
        $error("flash_mem_model: illegal parameters DQ_W=%0d LATENCY=%0d PROG_CYCLES=%0d",
               DQ_W, LATENCY, PROG_CYCLES);
    end

    logic [31:0] mem [DEPTH_WORDS] = '{default: 32'hFFFF_FFFF};

    typedef enum logic [1:0] {IDLE, ACCESS, VALID} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [DQ_W-1:0]   dout_q, dout_nxt;
    logic              rd_inc;
    logic              sel;
    logic              busy;
    logic [IDX_W-1:0]  word_idx;
    logic              in_range;
    logic [31:0]       word;
    logic [DQ_W-1:0]   lane_data;

    // Bit position of the lane addressed by a, honouring byte order and bus width.
    function automatic int lane_pos(input logic [ADDR_W-1:0] a);
        int l;
        l = (DQ_W == 16) ? int'(a[1]) : int'(a[1:0]);
        return BIG_ENDIAN ? (LANES - 1 - l) : l;
    endfunction

    assign sel       = ~bus.FL_CE_N & ~bus.FL_OE_N & bus.FL_WE_N;
    assign word_idx  = addr_q[ADDR_W-1:2];
    assign in_range  = 64'(word_idx) < 64'(DEPTH_WORDS);
    assign word      = in_range ? mem[word_idx[MEM_AW-1:0]] : 32'hFFFF_FFFF;
    assign lane_data = DQ_W'(word >> (DQ_W * lane_pos(addr_q)));

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        cnt_nxt   = cnt;
        dout_nxt  = dout_q;
        rd_inc    = 1'b0;
        unique case (state)
            IDLE: begin
                if (sel) begin
                    state_nxt = ACCESS;
                    addr_nxt  = bus.FL_ADDR;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            ACCESS: begin
                if (!sel) begin
                    state_nxt = IDLE;
                end else if (bus.FL_ADDR != addr_q) begin
                    addr_nxt = bus.FL_ADDR;
                    cnt_nxt  = CNT_LOAD;
                end else if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else if (!busy) begin
                    state_nxt = VALID;
                    dout_nxt  = lane_data;
                    rd_inc    = 1'b1;
                end
            end
            VALID: begin
                if (!sel) begin
                    state_nxt = IDLE;
                end else if (bus.FL_ADDR != addr_q) begin
                    state_nxt = ACCESS;
                    addr_nxt  = bus.FL_ADDR;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FL_RST_N behaves like Reset_n but keeps the debug read counter.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            cnt      <= '0;
            dout_q   <= '0;
            rd_count <= '0;
        end else if (!bus.FL_RST_N) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state    <= state_nxt;
            addr_q   <= addr_nxt;
            cnt      <= cnt_nxt;
            dout_q   <= dout_nxt;
            rd_count <= rd_count + 32'(rd_inc);
        end
    end

    assign FL_DQ = (state == VALID && sel) ? dout_q : {DQ_W{1'bz}};

`ifdef FLASH_PROGRAM_EN
    logic             we_q;
    logic [15:0]      busy_cnt;
    logic             we_rise;
    logic             prog_go;
    logic [IDX_W-1:0] prog_idx;
    logic [DQ_W-1:0]  dq_inv;
    logic [31:0]      prog_mask;

    assign busy      = (busy_cnt != 16'd0);
    assign we_rise   = ~we_q & bus.FL_WE_N & ~bus.FL_CE_N;
    assign prog_go   = we_rise & ~busy;
    assign prog_idx  = bus.FL_ADDR[ADDR_W-1:2];
    assign dq_inv    = ~FL_DQ;
    // All-ones except the addressed lane, which carries the programmed data.
    assign prog_mask = ~(32'(dq_inv) << (DQ_W * lane_pos(bus.FL_ADDR)));
    assign bus.FL_RY = ~busy;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            we_q     <= 1'b1;
            busy_cnt <= '0;
        end else if (!bus.FL_RST_N) begin
            we_q     <= bus.FL_WE_N;
            busy_cnt <= '0;
        end else begin
            we_q <= bus.FL_WE_N;
            if (prog_go)
                busy_cnt <= 16'(PROG_CYCLES);
            else if (busy)
                busy_cnt <= busy_cnt - 16'd1;
        end
    end

    // The write commits at capture, so an abort of the busy period keeps it.
    always_ff @(posedge clk) begin
        if (Reset_n && bus.FL_RST_N && prog_go && 64'(prog_idx) < 64'(DEPTH_WORDS))
            mem[prog_idx[MEM_AW-1:0]] <= mem[prog_idx[MEM_AW-1:0]] & prog_mask;
        if (Reset_n && bus.FL_RST_N && we_rise && busy)
            $warning("flash_mem_model: WE_N edge ignored while busy");
    end
`else
    assign busy      = 1'b0;
    assign bus.FL_RY = 1'b1;
`endif
endmodule

// File: tb/tb_flash_mem_model.sv
// Self-checking bench for flash_mem_model: an 8-bit big-endian and a 16-bit little-endian instance.
// A released bus reads as all-ones through the pull on the DQ nets.
module tb_flash_mem_model;
    localparam int AW  = 22;
    localparam int D8  = 64;
    localparam int D16 = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] addr;
    logic          ce8_n, ce16_n, oe_n, we_n, frst_n;
    logic          dq_en;
    logic [7:0]    dq_drv;
    tri1  [7:0]    dq8;
    tri1  [15:0]   dq16;
    logic [31:0]   rc8, rc16;

    logic [31:0]   img8  [D8];
    logic [31:0]   img16 [D16];
    int unsigned   exp_rc8, exp_rc16;
    int            n_tests, n_fail;

    flash_mem_model_if #(.ADDR_W(AW)) if8 ();
    flash_mem_model_if #(.ADDR_W(AW)) if16 ();

    assign if8.FL_ADDR   = addr;
    assign if8.FL_CE_N   = ce8_n;
    assign if8.FL_OE_N   = oe_n;
    assign if8.FL_WE_N   = we_n;
    assign if8.FL_RST_N  = frst_n;
    assign if16.FL_ADDR  = addr;
    assign if16.FL_CE_N  = ce16_n;
    assign if16.FL_OE_N  = oe_n;
    assign if16.FL_WE_N  = we_n;
    assign if16.FL_RST_N = frst_n;
    assign dq8 = dq_en ? dq_drv : 8'bz;

    flash_mem_model #(.ADDR_W(AW), .DQ_W(8), .DEPTH_WORDS(D8), .LATENCY(3),
                      .BIG_ENDIAN(1'b1), .PROG_CYCLES(8)) dut8 (
        .clk(clk), .Reset_n(reset_n), .bus(if8.slave), .FL_DQ(dq8), .rd_count(rc8));

    flash_mem_model #(.ADDR_W(AW), .DQ_W(16), .DEPTH_WORDS(D16), .LATENCY(1),
                      .BIG_ENDIAN(1'b0), .PROG_CYCLES(8)) dut16 (
        .clk(clk), .Reset_n(reset_n), .bus(if16.slave), .FL_DQ(dq16), .rd_count(rc16));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: byte/halfword picked from the image word with plain arithmetic.
    function automatic logic [15:0] model(input bit wide, input logic [AW-1:0] a);
        int unsigned w;
        logic [31:0] wd;
        w = int'(a / 4);
        if (wide) begin
            wd = (w < D16) ? img16[w] : 32'hFFFF_FFFF;
            return 16'((wd >> (16 * ((a % 4) / 2))) & 32'hFFFF);
        end
        wd = (w < D8) ? img8[w] : 32'hFFFF_FFFF;
        return 16'((wd >> (8 * (3 - (a % 4)))) & 32'hFF);
    endfunction

    function automatic logic [15:0] dq(input bit wide);
        return wide ? dq16 : {8'h00, dq8};
    endfunction

    function automatic logic [15:0] zval(input bit wide);
        return wide ? 16'hFFFF : 16'h00FF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ce8_n = 1'b1; ce16_n = 1'b1; oe_n = 1'b1;
        step();
    endtask

    // Select and hold: bus must stay released for LATENCY edges, then show the data.
    task automatic do_read(input bit wide, input logic [AW-1:0] a, input logic [15:0] exp,
                           input string nm);
        int lat;
        lat  = wide ? 1 : 3;
        addr = a;
        oe_n = 1'b0;
        if (wide) ce16_n = 1'b0; else ce8_n = 1'b0;
        for (int i = 0; i < lat; i++) begin
            step();
            chk({nm, "_z"}, 32'(dq(wide)), 32'(zval(wide)));
        end
        step();
        chk(nm, 32'(dq(wide)), 32'(exp));
        if (wide) exp_rc16++; else exp_rc8++;
    endtask

    typedef struct {
        bit            wide;
        logic [AW-1:0] a;
        logic [15:0]   exp;
        string         nm;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            wide, prev_wide, prev_act;
        logic [AW-1:0] a, prev_a;
        int            lows;

        n_tests = 0; n_fail = 0; exp_rc8 = 0; exp_rc16 = 0;
        reset_n = 1'b1; addr = '0; ce8_n = 1'b1; ce16_n = 1'b1; oe_n = 1'b1;
        we_n = 1'b1; frst_n = 1'b1; dq_en = 1'b0; dq_drv = '0;
        for (int i = 0; i < D8; i++)  img8[i]  = $urandom();
        for (int i = 0; i < D16; i++) img16[i] = $urandom();
        img8[0]      = 32'h3C1D_0010;
        img8[1]      = 32'hF0A5_5A0F;
        img8[D8-1]   = 32'h1234_5678;
        img16[0]     = 32'hAABB_CCDD;
        vecs[0]  = '{0, 22'd0,      16'h003C, "be_b0"};
        vecs[1]  = '{0, 22'd3,      16'h0010, "be_b3"};
        vecs[2]  = '{0, 22'd1,      16'h001D, "be_b1"};
        vecs[3]  = '{0, 22'd2,      16'h0000, "be_b2"};
        vecs[4]  = '{0, 22'(4*D8),  16'h00FF, "oor8"};
        vecs[5]  = '{0, 22'(4*D8-1),16'h0078, "last8"};
        vecs[6]  = '{1, 22'd0,      16'hCCDD, "le_h0"};
        vecs[7]  = '{1, 22'd2,      16'hAABB, "le_h1"};
        vecs[8]  = '{1, 22'd1,      16'hCCDD, "le_a1"};
        vecs[9]  = '{1, 22'd3,      16'hAABB, "le_a3"};
        vecs[10] = '{1, 22'(4*D16), 16'hFFFF, "oor16"};

        #1 reset_n = 1'b0;
        #1;
        for (int i = 0; i < D8; i++)  dut8.mem[i]  = img8[i];
        for (int i = 0; i < D16; i++) dut16.mem[i] = img16[i];
        chk("rst_rc8", rc8, 32'd0);
        chk("rst_rc16", rc16, 32'd0);
        chk("rst_ry8", 32'(if8.FL_RY), 32'd1);
        chk("rst_ry16", 32'(if16.FL_RY), 32'd1);
        chk("rst_dq8", 32'(dq8), 32'hFF);
        #10 reset_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            do_read(vecs[i].wide, vecs[i].a, vecs[i].exp, vecs[i].nm);
            idle();
        end
        chk("rc8_table", rc8, exp_rc8);
        chk("rc16_table", rc16, exp_rc16);

        // Address change mid-ACCESS restarts the full latency; byte 1 never appears.
        addr = 22'd1; ce8_n = 1'b0; oe_n = 1'b0;
        step(); chk("chg_pre_z", 32'(dq8), 32'hFF);
        step(); chk("chg_pre_z", 32'(dq8), 32'hFF);
        addr = 22'd2;
        for (int i = 0; i < 3; i++) begin
            step(); chk("chg_z", 32'(dq8), 32'hFF);
        end
        step(); chk("chg_data", 32'(dq8), 32'h00);
        exp_rc8++;

        // Page-style re-access from VALID.
        addr = 22'd0;
        for (int i = 0; i < 3; i++) begin
            step(); chk("page_z", 32'(dq8), 32'hFF);
        end
        step(); chk("page_data", 32'(dq8), 32'h3C);
        exp_rc8++;
        chk("rc8_page", rc8, exp_rc8);

        // OE_N release is combinational and returns the FSM to IDLE.
        oe_n = 1'b1;
        #1 chk("oe_release", 32'(dq8), 32'hFF);
        step();
        do_read(0, 22'd0, 16'h003C, "after_oe");

        // Async reset while VALID, then while ACCESS.
        do_read(0, 22'd3, 16'h0010, "pre_rst");
        reset_n = 1'b0;
        #1;
        chk("rst_valid_dq", 32'(dq8), 32'hFF);
        chk("rst_valid_rc", rc8, 32'd0);
        exp_rc8 = 0;
        exp_rc16 = 0;
        #2 reset_n = 1'b1;
        do_read(0, 22'd3, 16'h0010, "post_rst");
        addr = 22'd0;
        step(); chk("acc_z", 32'(dq8), 32'hFF);
        step();
        reset_n = 1'b0;
        #1 chk("rst_acc_rc", rc8, 32'd0);
        exp_rc8 = 0;
        #2 reset_n = 1'b1;
        do_read(0, 22'd0, 16'h003C, "post_rst_acc");
        chk("rc8_rst", rc8, exp_rc8);

        // FL_RST_N: synchronous, returns to IDLE, keeps rd_count.
        do_read(0, 22'd2, 16'h0000, "pre_flrst");
        frst_n = 1'b0;
        step();
        chk("flrst_dq", 32'(dq8), 32'hFF);
        chk("flrst_rc", rc8, exp_rc8);
        frst_n = 1'b1;
        do_read(0, 22'd2, 16'h0000, "post_flrst");
        idle();

        // Randomised reads, sometimes chained as page re-accesses.
        prev_act = 1'b0; prev_wide = 1'b0; prev_a = '0;
        for (int k = 0; k < 40; k++) begin
            wide = 1'($urandom_range(0, 1));
            a = wide ? 22'($urandom_range(0, 4*D16+7)) : 22'($urandom_range(0, 4*D8+7));
            if (prev_act && (wide != prev_wide || a == prev_a)) idle();
            do_read(wide, a, model(wide, a), "rand");
            prev_act  = 1'($urandom_range(0, 1));
            prev_wide = wide;
            prev_a    = a;
            if (!prev_act) idle();
        end
        if (prev_act) idle();
        chk("rc8_rand", rc8, exp_rc8);
        chk("rc16_rand", rc16, exp_rc16);

`ifdef FLASH_PROGRAM_EN
        // Program word 1 byte 0 (0xF0) with 0x3C, read during busy stalls.
        addr = 22'd4; dq_drv = 8'h3C; dq_en = 1'b1; ce8_n = 1'b0; oe_n = 1'b1; we_n = 1'b0;
        step();
        we_n = 1'b1;
        step();
        dq_en = 1'b0;
        img8[1] = img8[1] & 32'h3CFF_FFFF;
        chk("prog_ry", 32'(if8.FL_RY), 32'd0);
        addr = 22'd0; oe_n = 1'b0;
        lows = 1;
        while (if8.FL_RY == 1'b0 && lows < 40) begin
            step();
            chk("prog_stall", 32'(dq8), 32'hFF);
            if (if8.FL_RY == 1'b0) lows++;
        end
        chk("prog_busy_len", 32'(lows), 32'd8);
        step();
        chk("prog_read_after", 32'(dq8), 32'h3C);
        exp_rc8++;
        idle();
        do_read(0, 22'd4, model(0, 22'd4), "prog_result");
        chk("prog_result_val", 32'(model(0, 22'd4)), 32'h30);
        idle();
        chk("rc8_prog", rc8, exp_rc8);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
